dm_bus_arbiter: RTL and testbench
=================================

DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 The parameter list SHALL be: MAX_BURST, 8, maximum consecutive locked accesses granted to one master while the other waits.
REQ-002 The ports SHALL be: clk  in  1  system clock, rising-edge active; all state changes on this edge.
REQ-003 The ports SHALL include reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The master ports SHALL be, for X in {0,1} (0 = CPU, 1 = DMA): mX_req in 1; mX_rd in 1; mX_wr in 1; mX_lock in 1; mX_addr in 32; mX_wdata in 32.
REQ-005 The master responses SHALL be: mX_rdata out 32 (read data); mX_ack out 1 (access done this cycle); mX_err out 1 (illegal command this cycle).
REQ-006 The memory-side ports SHALL be: dm_cs out 1; dm_rd out 1; dm_wr out 1; dm_address out 32; dm_d_in out 32 (write data); dm_out in 32 (read data).

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1.
REQ-008 In IDLE, dm_cs/dm_rd/dm_wr SHALL be 0, dm_address and dm_d_in SHALL be 0, and all mX_ack/mX_err SHALL be 0.
REQ-009 From IDLE, one requester asserting req SHALL move the FSM to that master's GNT state on the next edge.
REQ-010 From IDLE with both requests asserted, the master not in last_grant SHALL win (round robin).
REQ-011 In GNTX with a legal command (exactly one of rd/wr), dm_cs SHALL be 1, dm_rd/dm_wr SHALL copy mX_rd/mX_wr, dm_address SHALL equal mX_addr, dm_d_in SHALL equal mX_wdata, and mX_ack SHALL be 1, all combinationally.
REQ-012 In GNTX, mX_rdata SHALL equal dm_out; the other master's rdata SHALL be 0.
REQ-013 In GNTX with an illegal command (rd=wr), the memory strobes SHALL stay 0 and mX_ack and mX_err SHALL both be 1 for that cycle.
REQ-014 Latency SHALL be one cycle: a request sampled in IDLE is acknowledged in the following cycle.
REQ-015 Masters SHALL hold req, rd, wr, addr and wdata stable until ack; the arbiter does not latch them.
REQ-016 The next state from GNTX SHALL be chosen by the first matching rule, with Y the other master:
  a) mX_req and mX_lock and burst_cnt < MAX_BURST-1: stay GNTX, burst_cnt+1.
  b) mY_req: go to GNTY, burst_cnt=0.
  c) mX_req and not mY_req: stay GNTX, burst_cnt=0.
  d) otherwise: go to IDLE, burst_cnt=0.
REQ-017 Under rule a), a lock with mY idle SHALL never be cut; once burst_cnt reaches MAX_BURST-1 with mY_req high, the grant SHALL pass to Y (starvation bound).
REQ-018 burst_cnt SHALL be ceil(log2(MAX_BURST)) bits wide, saturate at MAX_BURST-1, and never wrap.
REQ-019 last_grant SHALL update to X on every cycle spent in GNTX.
REQ-020 At no time SHALL both mX_ack signals be 1 in the same cycle.
REQ-021 When a master drops req in its grant cycle, no access SHALL occur (strobes 0, ack 0) and the next state follows REQ-016.

Reset
REQ-022 On reset the FSM SHALL go to IDLE, with burst_cnt=0 and last_grant=1 (CPU wins the first tie).
REQ-023 After reset, all outputs SHALL hold their IDLE values (REQ-008) from the cycle after the reset edge.
REQ-024 Reset during GNTX SHALL abort the grant at that edge with no ack in the following cycle, even when the request is held.

Structure
REQ-025 The state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the MAX_BURST default SHALL live in a shared package/include used by the arbiter and its bench.
REQ-026 The next-state and round-robin logic SHALL be one sub-module, rr_grant_fsm; the memory-side muxing SHALL stay in dm_bus_arbiter.

Verification
REQ-027 Single CPU write: m0 req/wr, addr 0x10, wdata 0xDEADBEEF -> next cycle dm_cs=1, dm_wr=1, dm_address=0x10, m0_ack=1; a later read of 0x10 returns m0_rdata=0xDEADBEEF.
REQ-028 Simultaneous requests after reset: m0 and m1 read on the same edge -> GNT0 first (m0_ack), then GNT1 (m1_ack) in the next cycle, with no idle gap.
REQ-029 Locked burst: m1 locked, reading 0x100..; m0 req raised in m1's first grant cycle -> m1 gets exactly 8 acks (MAX_BURST=8), then m0 is acked in the 9th grant cycle.
REQ-030 Illegal command: m0 rd=1, wr=1 -> m0_ack=1, m0_err=1, dm_cs=0, and memory contents unchanged.
REQ-031 Reset mid-burst: assert reset in m1's 3rd locked cycle, req held -> IDLE next cycle, no ack; the next m0/m1 tie is granted to m0.
REQ-032 A bench assertion SHALL check on every cycle that (m0_ack & m1_ack)==0 and that dm_rd & dm_wr is never 1.

Source files
------------

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared definitions for the two-master data-memory arbiter: state encoding,
// default burst limit and the burst counter width helper.
package dm_bus_arbiter_pkg;

   localparam int MAX_BURST_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   // A one-deep burst still needs a 1-bit counter to stay a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Bundle of both master request/response channels and the memory-side bus.
// The arbiter sits on the slave modport; masters and memory use master.
interface dm_bus_arbiter_if;

   logic        m0_req, m0_rd, m0_wr, m0_lock;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m0_ack, m0_err;

   logic        m1_req, m1_rd, m1_wr, m1_lock;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        m1_ack, m1_err;

   logic        dm_cs, dm_rd, dm_wr;
   logic [31:0] dm_address, dm_d_in, dm_out;

   modport slave (
      input  m0_req, m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata,
      output m0_rdata, m0_ack, m0_err,
      input  m1_req, m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata,
      output m1_rdata, m1_ack, m1_err,
      output dm_cs, dm_rd, dm_wr, dm_address, dm_d_in,
      input  dm_out
   );

   modport master (
      output m0_req, m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata,
      input  m0_rdata, m0_ack, m0_err,
      output m1_req, m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata,
      input  m1_rdata, m1_ack, m1_err,
      input  dm_cs, dm_rd, dm_wr, dm_address, dm_d_in,
      output dm_out
   );

endinterface

// File: rtl/dm_bus_arbiter_grant.sv
// Round-robin grant FSM with bounded locked bursts; the state register is the
// only output and drives all memory-side muxing in the arbiter top.
module rr_grant_fsm
   import dm_bus_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output arb_state_t state
);

   localparam int             CW      = cnt_width(MAX_BURST);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

   logic [CW-1:0] burst_cnt;
   logic          last_grant;
   logic          own;
   logic          other;

   assign own   = (state == GNT1);
   assign other = ~own;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               if (req[0] && req[1])
                  state <= last_grant ? GNT0 : GNT1;
               else if (req[0])
                  state <= GNT0;
               else if (req[1])
                  state <= GNT1;
            end
            GNT0, GNT1: begin
               last_grant <= own;
               // The counter check is what caps a lock while the other master waits.
               if (req[own] && lock[own] && (burst_cnt < CNT_MAX)) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  burst_cnt <= '0;
                  if (req[other])
                     state <= other ? GNT1 : GNT0;
                  else if (!req[own])
                     state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-master (CPU/DMA) data-memory arbiter: steers the granted master onto the
// single-cycle memory bus and returns ack/err/rdata combinationally.
module dm_bus_arbiter
   import dm_bus_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic             clk,
   input  logic             reset,
   dm_bus_arbiter_if.slave  bus
);

   arb_state_t  state;
   logic        sel1;
   logic        granted;
   logic        active;
   logic        legal;
   logic        sel_req;
   logic        sel_rd;
   logic        sel_wr;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   rr_grant_fsm #(
      .MAX_BURST (MAX_BURST)
   ) u_fsm (
      .clk   (clk),
      .reset (reset),
      .req   ({bus.m1_req,  bus.m0_req}),
      .lock  ({bus.m1_lock, bus.m0_lock}),
      .state (state)
   );

   assign sel1      = (state == GNT1);
   assign granted   = (state == GNT0) || sel1;
   assign sel_req   = sel1 ? bus.m1_req   : bus.m0_req;
   assign sel_rd    = sel1 ? bus.m1_rd    : bus.m0_rd;
   assign sel_wr    = sel1 ? bus.m1_wr    : bus.m0_wr;
   assign sel_addr  = sel1 ? bus.m1_addr  : bus.m0_addr;
   assign sel_wdata = sel1 ? bus.m1_wdata : bus.m0_wdata;

   // A granted master that has already withdrawn its request gets no access.
   assign active = granted && sel_req;
   assign legal  = active && (sel_rd ^ sel_wr);

   assign bus.dm_cs      = legal;
   assign bus.dm_rd      = legal && sel_rd;
   assign bus.dm_wr      = legal && sel_wr;
   assign bus.dm_address = legal ? sel_addr  : '0;
   assign bus.dm_d_in    = legal ? sel_wdata : '0;

   assign bus.m0_ack   = active && !sel1;
   assign bus.m1_ack   = active && sel1;
   assign bus.m0_err   = active && !sel1 && !legal;
   assign bus.m1_err   = active && sel1 && !legal;
   assign bus.m0_rdata = (state == GNT0) ? bus.dm_out : '0;
   assign bus.m1_rdata = (state == GNT1) ? bus.dm_out : '0;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed and randomized bench for dm_bus_arbiter against a cycle-level
// ownership model of the two masters and a reference memory image.
module tb_dm_bus_arbiter;
   import dm_bus_arbiter_pkg::*;

   localparam int MB = MAX_BURST_DEF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_bus_arbiter_if bus ();

   dm_bus_arbiter #(.MAX_BURST(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic        req   [2];
   logic        rd    [2];
   logic        wr    [2];
   logic        lock  [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];

   assign bus.m0_req   = req[0];
   assign bus.m0_rd    = rd[0];
   assign bus.m0_wr    = wr[0];
   assign bus.m0_lock  = lock[0];
   assign bus.m0_addr  = addr[0];
   assign bus.m0_wdata = wdata[0];
   assign bus.m1_req   = req[1];
   assign bus.m1_rd    = rd[1];
   assign bus.m1_wr    = wr[1];
   assign bus.m1_lock  = lock[1];
   assign bus.m1_addr  = addr[1];
   assign bus.m1_wdata = wdata[1];

   // Memory device: asynchronous read, write on the clock edge.
   logic        mem_clear;
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (bus.dm_cs && bus.dm_wr) begin
         mem[bus.dm_address[9:2]] <= bus.dm_d_in;
      end
   end
   assign bus.dm_out = mem[bus.dm_address[9:2]];

   int tests;
   int fails;

   // Reference model: who owns the bus (-1 = nobody), length of the current
   // locked run, and the master that most recently owned the bus.
   int          owner;
   int          run_len;
   int          prev_owner;
   logic [31:0] ref_mem [0:255];

   logic        e_ack [2];
   logic        e_err [2];
   logic        e_cs, e_rd, e_wr;
   logic [31:0] e_addr, e_wd;

   logic        o_ack [2];
   logic        o_err0, o_cs, o_wr;
   logic [31:0] o_addr, o_rdata0;

   task automatic chk1(input string tag, input logic got, input logic exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_cycle();
      int   x;
      logic ok_cmd;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      e_err[0] = 1'b0; e_err[1] = 1'b0;
      e_cs = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_addr = '0; e_wd = '0;
      if (owner >= 0) begin
         x        = owner;
         ok_cmd   = req[x] && (rd[x] != wr[x]);
         e_ack[x] = req[x];
         e_err[x] = req[x] && !ok_cmd;
         e_cs     = ok_cmd;
         e_rd     = ok_cmd && rd[x];
         e_wr     = ok_cmd && wr[x];
         e_addr   = ok_cmd ? addr[x]  : 32'h0;
         e_wd     = ok_cmd ? wdata[x] : 32'h0;
      end
      o_ack[0] = bus.m0_ack;
      o_ack[1] = bus.m1_ack;
      o_err0   = bus.m0_err;
      o_cs     = bus.dm_cs;
      o_wr     = bus.dm_wr;
      o_addr   = bus.dm_address;
      o_rdata0 = bus.m0_rdata;
      chk1 ("m0_ack",     bus.m0_ack,     e_ack[0]);
      chk1 ("m1_ack",     bus.m1_ack,     e_ack[1]);
      chk1 ("m0_err",     bus.m0_err,     e_err[0]);
      chk1 ("m1_err",     bus.m1_err,     e_err[1]);
      chk1 ("dm_cs",      bus.dm_cs,      e_cs);
      chk1 ("dm_rd",      bus.dm_rd,      e_rd);
      chk1 ("dm_wr",      bus.dm_wr,      e_wr);
      chk32("dm_address", bus.dm_address, e_addr);
      chk32("dm_d_in",    bus.dm_d_in,    e_wd);
      if (owner == 0) begin
         chk32("m1_rdata_zero", bus.m1_rdata, 32'h0);
         if (e_rd) chk32("m0_rdata", bus.m0_rdata, ref_mem[addr[0][9:2]]);
      end
      if (owner == 1) begin
         chk32("m0_rdata_zero", bus.m0_rdata, 32'h0);
         if (e_rd) chk32("m1_rdata", bus.m1_rdata, ref_mem[addr[1][9:2]]);
      end
      chk1("ack_exclusive", bus.m0_ack & bus.m1_ack, 1'b0);
      chk1("rd_wr_exclusive", bus.dm_rd & bus.dm_wr, 1'b0);
   endtask

   task automatic model_step(input logic rst_in);
      int x;
      int y;
      if (e_cs && e_wr) ref_mem[e_addr[9:2]] = e_wd;
      if (rst_in) begin
         owner = -1; run_len = 0; prev_owner = 1;
      end else if (owner < 0) begin
         run_len = 0;
         if (req[0] && req[1]) owner = 1 - prev_owner;
         else if (req[0])      owner = 0;
         else if (req[1])      owner = 1;
      end else begin
         x = owner;
         y = 1 - owner;
         prev_owner = x;
         if (req[x] && lock[x] && run_len < MB - 1) begin
            run_len++;
         end else begin
            run_len = 0;
            if (req[y])       owner = y;
            else if (!req[x]) owner = -1;
         end
      end
   endtask

   task automatic cyc(input logic rst_in);
      reset = rst_in;
      #1;
      check_cycle();
      model_step(rst_in);
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int x, input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
      req[x] = 1'b1; rd[x] = r; wr[x] = w; lock[x] = l; addr[x] = a; wdata[x] = d;
   endtask

   task automatic new_txn(input int x);
      logic [3:0] k;
      k = 4'($urandom_range(0, 15));
      req[x]   = 1'b1;
      lock[x]  = 1'($urandom_range(0, 1));
      addr[x]  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      wdata[x] = $urandom;
      if (k == 4'd0)      begin rd[x] = 1'b1; wr[x] = 1'b1; end
      else if (k == 4'd1) begin rd[x] = 1'b0; wr[x] = 1'b0; end
      else                begin rd[x] = k[0]; wr[x] = ~k[0]; end
   endtask

   initial begin
      int n1;
      int k;
      tests = 0; fails = 0;
      mem_clear = 1'b1; reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; rd[i] = 0; wr[i] = 0; lock[i] = 0; addr[i] = '0; wdata[i] = '0;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      owner = -1; run_len = 0; prev_owner = 1;
      repeat (3) @(posedge clk);
      #1;
      mem_clear = 1'b0;

      // Reset state and idle bus
      cyc(1'b1); cyc(1'b0); cyc(1'b0);
      chk1 ("rst_idle_cs",   o_cs,     1'b0);
      chk1 ("rst_idle_ack0", o_ack[0], 1'b0);
      chk32("rst_idle_addr", o_addr,   32'h0);

      // Single CPU write then read back
      set_m(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      cyc(1'b0);
      chk1("wr_first_cycle_noack", o_ack[0], 1'b0);
      cyc(1'b0);
      chk1 ("wr_ack",  o_ack[0], 1'b1);
      chk1 ("wr_cs",   o_cs,     1'b1);
      chk1 ("wr_dmwr", o_wr,     1'b1);
      chk32("wr_addr", o_addr,   32'h10);
      req[0] = 1'b0; cyc(1'b0); cyc(1'b0);
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      cyc(1'b0); cyc(1'b0);
      chk32("rd_back", o_rdata0, 32'hDEADBEEF);
      req[0] = 1'b0; cyc(1'b0); cyc(1'b0);

      // Simultaneous requests after reset
      cyc(1'b1);
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      cyc(1'b0);
      cyc(1'b0);
      chk1("tie_m0_first", o_ack[0], 1'b1);
      chk1("tie_m1_waits", o_ack[1], 1'b0);
      req[0] = 1'b0;
      cyc(1'b0);
      chk1("tie_m1_next", o_ack[1], 1'b1);
      req[1] = 1'b0; cyc(1'b0); cyc(1'b0);

      // Locked burst from m1 with m0 waiting
      set_m(1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
      cyc(1'b0);
      set_m(0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0BADF00D);
      n1 = 0; k = 0;
      for (int c = 1; c <= 12 && k == 0; c++) begin
         cyc(1'b0);
         if (o_ack[1]) begin n1++; addr[1] = addr[1] + 32'd4; end
         if (o_ack[0]) begin k = c; req[0] = 1'b0; end
      end
      chk32("burst_m1_acks",     32'(n1), 32'(MB));
      chk32("burst_m0_ack_slot", 32'(k),  32'(MB + 1));
      req[1] = 1'b0; lock[1] = 1'b0;
      cyc(1'b0); cyc(1'b0); cyc(1'b0);

      // Illegal command leaves memory untouched
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h12345678);
      cyc(1'b0); cyc(1'b0);
      chk1("ill_ack", o_ack[0], 1'b1);
      chk1("ill_err", o_err0,   1'b1);
      chk1("ill_cs",  o_cs,     1'b0);
      req[0] = 1'b0; cyc(1'b0); cyc(1'b0);
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      cyc(1'b0); cyc(1'b0);
      chk32("ill_mem_kept", o_rdata0, 32'hDEADBEEF);
      req[0] = 1'b0; cyc(1'b0); cyc(1'b0);

      // Reset in the third locked cycle of an m1 burst
      set_m(1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
      cyc(1'b0);
      cyc(1'b0); cyc(1'b0);
      cyc(1'b1);
      chk1("burst3_acked", o_ack[1], 1'b1);
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      cyc(1'b0);
      chk1("rst_abort_noack", o_ack[1], 1'b0);
      chk1("rst_abort_cs",    o_cs,     1'b0);
      cyc(1'b0);
      chk1("post_rst_tie_m0", o_ack[0], 1'b1);
      chk1("post_rst_tie_m1", o_ack[1], 1'b0);
      req[0] = 1'b0; req[1] = 1'b0; lock[1] = 1'b0;
      cyc(1'b0); cyc(1'b0); cyc(1'b0);

      // Randomized traffic from both masters with occasional resets
      for (int c = 0; c < 800; c++) begin
         cyc(1'($urandom_range(0, 99) == 0));
         for (int x = 0; x < 2; x++) begin
            if (req[x] && e_ack[x]) req[x] = 1'b0;
            if (!req[x] && $urandom_range(0, 2) == 0) new_txn(x);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
